ou_sched: RTL

Request scheduler for the shared operational unit (OU) and its microprogrammed control unit (CU). It arbitrates up to N_REQ requesters round-robin, loads the granted requester's operands into the OU, and pulses the CU start flag. It then waits for CU completion (Z), error-termination codes or a watchdog timeout, and returns status and result to the granted requester. It sits between the client logic and the OU/CU pair.

---
 rtl/ou_pkg.sv | 27 ++
 rtl/ou_sched_rr_arb.sv | 36 +++
 rtl/ou_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ou_pkg.sv
// Shared definitions for the OU/CU request scheduler.
//   - FSM state encodings (legacy-compatible constants)
//   - status codes returned with ack
//   - bit positions inside the CU control words
package ou_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_LOAD  = 3'd1;
   localparam state_t S_START = 3'd2;
   localparam state_t S_RUN   = 3'd3;
   localparam state_t S_RESP  = 3'd4;

   typedef logic [1:0] status_t;

   localparam status_t ST_OK   = 2'b00;
   localparam status_t ST_ERR1 = 2'b01;
   localparam status_t ST_ERR2 = 2'b10;
   localparam status_t ST_TMO  = 2'b11;

   localparam int CU_W    = 12;
   localparam int P_START = 9;   // CU p-side start input, driven by cu_start
   localparam int Y_ERR1  = 9;
   localparam int Y_ERR2  = 10;

endpackage

// File: rtl/ou_sched_rr_arb.sv
// Round-robin pick for the OU scheduler (purely combinational).
//   req     : request levels
//   rr_ptr  : highest-priority requester for this pick
//   any     : at least one request present
//   pick    : one-hot of the chosen requester
//   idx     : index of the chosen requester
module rr_arb #(
   parameter int N_REQ = 2,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any,
   output logic [N_REQ-1:0] pick,
   output logic [IDX_W-1:0] idx
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest set bit at or
   // after rr_ptr is the last one written and therefore wins.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = (int'(rr_ptr) + off) % N_REQ;
         if (req[cand]) begin
            any = 1'b1;
            idx = IDX_W'(cand);
         end
      end
      pick = any ? (N_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/ou_sched.sv
// Request scheduler for the shared OU and its microprogrammed CU.
// Arbitrates requesters round-robin, loads the winner's operands into the
// OU, kicks the CU and returns status/result once the CU finishes, flags an
// error, or the watchdog expires.
//   clk, rst            : clock, synchronous active-high reset
//   req, op_a, op_b     : per-requester request level and operand slices
//   gnt, ack            : one-hot grant (LOAD..RESP), one-cycle completion
//   status, result      : valid with ack; result is zero unless status is OK
//   ou_a, ou_b, ou_load : registered operands and load strobe to the OU
//   cu_rst, cu_start    : CU re-init pulse and start flag
//   cu_y, cu_z, ou_res  : CU control word, CU done flag, OU result bus
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for any request; picks winner, latches operands
// LOAD    | grant shown, ou_load and cu_rst pulsed
// START   | cu_start raised, watchdog loaded
// RUN     | waiting for Z, error code or watchdog terminal count
// RESP    | ack to winner with status/result, advance round-robin pointer
module ou_sched
   import ou_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int DATA_W  = 8,
   parameter int TMO_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] op_a,
   input  logic [N_REQ*DATA_W-1:0] op_b,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        ack,
   output logic [1:0]              status,
   output logic [DATA_W-1:0]       result,
   output logic [DATA_W-1:0]       ou_a,
   output logic [DATA_W-1:0]       ou_b,
   output logic                    ou_load,
   output logic                    cu_rst,
   output logic                    cu_start,
   input  logic [CU_W-1:0]         cu_y,
   input  logic                    cu_z,
   input  logic [DATA_W-1:0]       ou_res
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TMO_CYC);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [N_REQ-1:0] gnt_oh;
   logic [WD_W-1:0]  wd_cnt;
   logic             start_hold;

   logic             arb_any;
   logic [N_REQ-1:0] arb_pick;
   logic [IDX_W-1:0] arb_idx;

   rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .any    (arb_any),
      .pick   (arb_pick),
      .idx    (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         rr_ptr     <= '0;
         gnt_oh     <= '0;
         wd_cnt     <= '0;
         start_hold <= 1'b0;
         status     <= ST_OK;
         result     <= '0;
         ou_a       <= '0;
         ou_b       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  idx    <= arb_idx;
                  gnt_oh <= arb_pick;
                  ou_a   <= op_a[int'(arb_idx)*DATA_W +: DATA_W];
                  ou_b   <= op_b[int'(arb_idx)*DATA_W +: DATA_W];
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               start_hold <= 1'b1;
               state      <= S_START;
            end
            S_START: begin
               // Watchdog counts down; terminal count 0 is reached on the
               // TMO_CYC-th RUN cycle and the counter never goes below it.
               wd_cnt <= WD_W'(TMO_CYC - 1);
               state  <= S_RUN;
            end
            S_RUN: begin
               // Once the CU shows any activity it has seen the start flag.
               if (cu_y != '0)
                  start_hold <= 1'b0;
               if (cu_z) begin
                  status <= ST_OK;
                  result <= ou_res;
                  state  <= S_RESP;
               end else if (cu_y[Y_ERR2]) begin
                  status <= ST_ERR2;
                  result <= '0;
                  state  <= S_RESP;
               end else if (cu_y[Y_ERR1]) begin
                  status <= ST_ERR1;
                  result <= '0;
                  state  <= S_RESP;
               end else if (wd_cnt == '0) begin
                  status <= ST_TMO;
                  result <= '0;
                  state  <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            S_RESP: begin
               rr_ptr     <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
               start_hold <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign gnt      = (state != S_IDLE) ? gnt_oh : '0;
   assign ack      = (state == S_RESP) ? gnt_oh : '0;
   assign ou_load  = (state == S_LOAD);
   assign cu_rst   = rst || (state == S_LOAD);
   assign cu_start = start_hold && ((state == S_START) || (state == S_RUN));

endmodule
